// File: rtl/sync_pkg.sv
// Shared helpers for Gray-pointer clock-domain crossing: Gray/binary
// conversion, single-bit step check and synchroniser depth limits.
package sync_pkg;

    localparam int unsigned STAGES_MIN = 2;
    localparam int unsigned STAGES_MAX = 4;
    localparam int unsigned PTR_MAX_W  = 32;

    // Operates on the widest supported pointer; zero upper bits leave the
    // low-order result unchanged, so callers zero-extend and cast back.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic one_bit_step(input logic [PTR_MAX_W-1:0] a,
                                          input logic [PTR_MAX_W-1:0] b);
        return ($countones(a ^ b) <= 1);
    endfunction

endpackage

// File: rtl/sync_gray_ptr.sv
// Synchronises a foreign-domain Gray pointer into rd_clk, converts it to binary
// and flags any multi-bit step seen at the output.
module sync_gray_ptr
    import sync_pkg::*;
#(
    parameter int unsigned ADDR   = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic            rd_clk,
    input  logic            rst,
    input  logic [ADDR:0]   gr_ptr_in,
    input  logic            err_clr,
    output logic [ADDR:0]   sync_gr_ptr,
    output logic [ADDR:0]   sync_bin_ptr,
    output logic            ptr_upd,
    output logic            ptr_err
);

    localparam int unsigned PTR_W = ADDR + 1;

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX || PTR_W > PTR_MAX_W) begin : gen_bad_param
        $error("sync_gray_ptr: STAGES must be in 2..4 and ADDR+1 must not exceed 32");
    end

    for (genvar i = 0; i < STAGES; i++) begin : gen_sync
        logic [PTR_W-1:0] stage_d;
        (* async_reg = "true" *) logic [PTR_W-1:0] stage_q;

        if (i == 0) begin : gen_first
            assign stage_d = gr_ptr_in;
        end else begin : gen_next
            assign stage_d = gen_sync[i-1].stage_q;
        end

        always_ff @(posedge rd_clk) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    logic [PTR_W-1:0] sync_last;
    assign sync_last = gen_sync[STAGES-1].stage_q;

    logic [PTR_W-1:0] gr_d, gr_q;
    logic [PTR_W-1:0] bin_d, bin_q;
    logic             upd_d, upd_q;
    logic             err_d, err_q;
    logic             illegal_step;

    always_comb begin
        gr_d         = sync_last;
        bin_d        = PTR_W'(gray2bin(PTR_MAX_W'(sync_last)));
        upd_d        = (sync_last != gr_q);
        illegal_step = !one_bit_step(PTR_MAX_W'(sync_last), PTR_MAX_W'(gr_q));
        err_d        = err_q;
        // A new illegal step takes priority over a simultaneous clear.
        if (illegal_step) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            gr_q  <= '0;
            bin_q <= '0;
            upd_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            gr_q  <= gr_d;
            bin_q <= bin_d;
            upd_q <= upd_d;
            err_q <= err_d;
        end
    end

    assign sync_gr_ptr  = gr_q;
    assign sync_bin_ptr = bin_q;
    assign ptr_upd      = upd_q;
    assign ptr_err      = err_q;

endmodule

// File: tb/tb_sync_gray_ptr.sv
// Scoreboard bench: three instances (STAGES 2, 3, 4) share one stimulus stream;
// each keeps a queue of in-flight pointers and checks every output each edge.
module tb_sync_gray_ptr;

    localparam int unsigned ADDR = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ADDR:0]   gr_in = '0;
    logic            err_clr = 1'b0;
    logic            count_win = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [ADDR:0] ref_g2b(input logic [ADDR:0] g);
        logic [ADDR:0] b;
        for (int i = 0; i <= ADDR; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic logic [ADDR:0] bin2gray(input int unsigned v);
        logic [ADDR:0] b;
        b = v[ADDR:0];
        return b ^ (b >> 1);
    endfunction

    for (genvar k = 0; k < 3; k++) begin : gen_dut
        localparam int unsigned STG = k + 2;

        logic [ADDR:0] d_gr, d_bin;
        logic          d_upd, d_err;

        sync_gray_ptr #(
            .ADDR   (ADDR),
            .STAGES (STG)
        ) u_dut (
            .rd_clk       (clk),
            .rst          (rst),
            .gr_ptr_in    (gr_in),
            .err_clr      (err_clr),
            .sync_gr_ptr  (d_gr),
            .sync_bin_ptr (d_bin),
            .ptr_upd      (d_upd),
            .ptr_err      (d_err)
        );

        logic [ADDR:0] pipe[$];
        logic [ADDR:0] exp_gr = '0;
        logic          exp_upd = 1'b0;
        logic          exp_err = 1'b0;
        bit            started = 1'b0;
        bit            lat_done = 1'b0;
        int            edge_cnt = 0;
        int            upd_cnt = 0;

        always @(posedge clk) begin
            logic [ADDR:0] nxt;
            if (rst) begin
                pipe.delete();
                for (int i = 0; i < int'(STG); i++) pipe.push_back('0);
                exp_gr   = '0;
                exp_upd  = 1'b0;
                exp_err  = 1'b0;
                edge_cnt = 0;
                started  = 1'b1;
            end else if (started) begin
                nxt = pipe.pop_front();
                pipe.push_back(gr_in);
                exp_upd = (nxt != exp_gr);
                if ($countones(nxt ^ exp_gr) > 1) exp_err = 1'b1;
                else if (err_clr) exp_err = 1'b0;
                exp_gr = nxt;
                edge_cnt++;
            end
            #1;
            if (started) begin
                check_val($sformatf("s%0d_gr", STG), 32'(d_gr), 32'(exp_gr));
                check_val($sformatf("s%0d_bin", STG), 32'(d_bin), 32'(ref_g2b(exp_gr)));
                check_val($sformatf("s%0d_upd", STG), 32'(d_upd), 32'(exp_upd));
                check_val($sformatf("s%0d_err", STG), 32'(d_err), 32'(exp_err));
                if (!lat_done && d_upd === 1'b1) begin
                    lat_done = 1'b1;
                    check_val($sformatf("s%0d_latency", STG), 32'(edge_cnt), 32'(STG + 1));
                end
                if (count_win && d_upd === 1'b1) upd_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset, then hold 00001 to observe first-value latency.
        rst = 1'b1;
        step(2);
        rst   = 1'b0;
        gr_in = 5'b00001;
        step(8);

        // Full Gray count with wrap, counting update pulses.
        rst   = 1'b1;
        gr_in = '0;
        step(2);
        rst       = 1'b0;
        count_win = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            gr_in = bin2gray(i % 32);
            step(2);
        end
        step(8);
        count_win = 1'b0;

        // Illegal two-bit step, then clear.
        gr_in = 5'b00000;
        step(8);
        gr_in = 5'b00011;
        step(8);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        step(4);

        // Illegal step arriving while err_clr is held high: set must win.
        gr_in   = 5'b00000;
        err_clr = 1'b1;
        step(7);
        err_clr = 1'b0;
        step(4);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        step(2);

        // Counting with a one-cycle reset mid-stream.
        for (int i = 0; i < 20; i++) begin
            gr_in = bin2gray(i);
            if (i == 9) rst = 1'b1;
            step(1);
            rst = 1'b0;
        end
        step(8);

        check_val("s2_upd_count", 32'(gen_dut[0].upd_cnt), 32'd32);
        check_val("s3_upd_count", 32'(gen_dut[1].upd_cnt), 32'd32);
        check_val("s4_upd_count", 32'(gen_dut[2].upd_cnt), 32'd32);
        check_val("s2_latency_seen", 32'(gen_dut[0].lat_done), 32'd1);
        check_val("s3_latency_seen", 32'(gen_dut[1].lat_done), 32'd1);
        check_val("s4_latency_seen", 32'(gen_dut[2].lat_done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_gray_ptr.md
SYNC_GRAY_PTR -- requirements
Module: sync_gray_ptr

Interface
REQ-001 Parameter ADDR, default 4: pointer width is ADDR+1 bits (address plus wrap bit).
REQ-002 Parameter STAGES, default 2: number of synchroniser flops; legal range 2..4.
REQ-003 rd_clk  in  1  destination-domain clock; the only clock in the block.
REQ-004 rst  in  1  reset: synchronous, active-high, sampled on rising rd_clk.
REQ-005 gr_ptr_in  in  ADDR+1  Gray-coded pointer from the foreign domain; asynchronous to rd_clk.
REQ-006 err_clr  in  1  synchronous clear of ptr_err.
REQ-007 sync_gr_ptr  out  ADDR+1  synchronised Gray pointer, registered.
REQ-008 sync_bin_ptr  out  ADDR+1  binary equivalent of sync_gr_ptr, registered, cycle-aligned with it.
REQ-009 ptr_upd  out  1  one-cycle pulse when the outputs take a new value.
REQ-010 ptr_err  out  1  sticky flag: an illegal multi-bit Gray step was seen.

Function
REQ-011 The block SHALL capture gr_ptr_in through a chain of STAGES flops, then one output register stage.
REQ-012 Latency SHALL be STAGES+1 rd_clk edges from a stable gr_ptr_in to sync_gr_ptr/sync_bin_ptr.
REQ-013 sync_bin_ptr SHALL be the Gray-to-binary conversion of the last sync stage: bin[ADDR]=g[ADDR]; bin[i]=bin[i+1] XOR g[i].
REQ-014 sync_gr_ptr and sync_bin_ptr SHALL update on the same edge; no combinational path from gr_ptr_in to any output.
REQ-015 ptr_upd SHALL be high for exactly the cycle in which the output registers hold a value different from the previous cycle.
REQ-016 Repeated identical input SHALL produce no ptr_upd.
REQ-017 Step check: when the new output value differs from the old in more than one bit, ptr_err SHALL go high on that same edge and stay high.
REQ-018 A step of exactly one bit, including wrap-around (e.g. ADDR=4: 5'b10000 -> 5'b00000), SHALL be legal.
REQ-019 err_clr high SHALL clear ptr_err on the next edge.
REQ-020 err_clr and a new illegal step on the same edge SHALL leave ptr_err set (set wins).
REQ-021 Width arithmetic SHALL be exactly ADDR+1 bits; no truncation or extension.

Reset
REQ-022 While rst is high at an edge, all sync stages, sync_gr_ptr, sync_bin_ptr and ptr_err SHALL load 0, and ptr_upd SHALL be 0.
REQ-023 rst asserted mid-operation SHALL discard all in-flight values; no ptr_upd for the reset transition itself.
REQ-024 The first edge after rst deasserts SHALL compare against the reset value 0 for ptr_upd/ptr_err purposes.
REQ-025 With gr_ptr_in stable at value V through deassertion, outputs SHALL show V on the (STAGES+1)-th edge after deassertion.

Structure
REQ-026 Shared package sync_pkg SHALL hold the gray2bin function, the one-bit-step (popcount of XOR <= 1) check function and constants STAGES_MIN=2, STAGES_MAX=4.
REQ-027 Elaboration SHALL fail if STAGES is outside STAGES_MIN..STAGES_MAX.
REQ-028 No sub-module: the block is one module with a generate-built flop chain.
REQ-029 The sync-chain flops SHALL carry the team's synchroniser attribute so synthesis and CDC tools recognise them.

Verification
REQ-030 ADDR=4, STAGES=2: rst 2 cycles, then gr_ptr_in=5'b00001 held -> on edge 3 after deassert sync_gr_ptr=00001, sync_bin_ptr=00001, ptr_upd=1 for that one cycle.
REQ-031 Gray count 0..31 then wrap to 0, one step per 2 cycles -> sync_bin_ptr follows 0..31,0 with no gaps; ptr_err stays 0; 32 ptr_upd pulses.
REQ-032 Inject 00000 -> 00011 -> ptr_err=1 on the edge the output shows 00011 and stays 1. Then err_clr=1 for one cycle -> ptr_err=0.
REQ-033 An illegal step coinciding with err_clr=1 -> ptr_err stays 1.
REQ-034 Counting up, assert rst for 1 cycle mid-stream -> all outputs 0 the next cycle and no ptr_upd. After release, outputs show the live input after STAGES+1 edges.
REQ-035 Repeat REQ-030 and REQ-031 with STAGES=3 and STAGES=4 -> latency 4 and 5 edges respectively. An elaboration with STAGES=1 fails.
